// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline constants and the fetch FSM state encoding.
package rv32i_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          PC_INC       = 4;

  typedef enum logic [1:0] {
    FETCH_START   = 2'd0,
    FETCH_RUN     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/rv32i_fetch_buffer.sv
// Single-entry instruction+PC holding register with valid/load/take/flush.
module rv32i_fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            i_load,
  input  logic            i_take,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);
  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // load beats take so a same-cycle refill keeps the entry valid
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else begin
      if (i_flush)     r_valid <= 1'b0;
      else if (i_load) r_valid <= 1'b1;
      else if (i_take) r_valid <= 1'b0;
      if (i_load && !i_flush) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/rv32i_fetch.sv
// rv32i instruction fetch: PC, hold-until-ack imem bus, decode handshake, redirect flush.
// Define RV32I_FETCH_PREFETCH_EN to add a one-entry prefetch buffer behind the output slot.
module rv32i_fetch
  import rv32i_pkg::*;
#(
  parameter int              XLEN         = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rv32i_pkg::RESET_VECTOR)
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_data_i,
  output logic            data_ready_o,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            downstream_stall_i,
  input  logic            downstream_execute_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    r_state, w_state_n;
  logic [XLEN-1:0] r_pc, r_addr;
  logic            r_pend;
  logic            w_req, w_room, w_cap;
  logic            w_slot_vld, w_slot_take, w_slot_load;
  logic [XLEN-1:0] w_slot_instr_in, w_slot_pc_in;
  logic            w_unused_stall;

  // stall only matters through the slot-free rule
  assign w_unused_stall = downstream_stall_i;

  assign w_slot_take = downstream_execute_i & w_slot_vld;
  assign w_cap       = imem_ack_i & w_req & (r_state == FETCH_RUN) & ~redirect_i;

`ifdef RV32I_FETCH_PREFETCH_EN
  logic            w_buf_vld, w_buf_load, w_buf_take, w_slot_free;
  logic [XLEN-1:0] w_buf_instr, w_buf_pc;

  assign w_slot_free     = ~w_slot_vld | w_slot_take;
  assign w_room          = ~w_buf_vld | w_slot_take;
  assign w_slot_load     = w_slot_free & (w_buf_vld | w_cap);
  assign w_slot_instr_in = w_buf_vld ? w_buf_instr : imem_data_i;
  assign w_slot_pc_in    = w_buf_vld ? w_buf_pc : r_pc;
  // the buffer takes the response unless it can go straight into the slot
  assign w_buf_load      = w_cap & ~(w_slot_free & ~w_buf_vld);
  assign w_buf_take      = w_buf_vld & w_slot_free;

  rv32i_fetch_buffer #(.XLEN(XLEN)) u_pf (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .i_load  (w_buf_load),
    .i_take  (w_buf_take),
    .i_flush (redirect_i),
    .i_instr (imem_data_i),
    .i_pc    (r_pc),
    .o_valid (w_buf_vld),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );
`else
  assign w_room          = ~w_slot_vld | downstream_execute_i;
  assign w_slot_load     = w_cap;
  assign w_slot_instr_in = imem_data_i;
  assign w_slot_pc_in    = r_pc;
`endif

  rv32i_fetch_buffer #(.XLEN(XLEN)) u_slot (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .i_load  (w_slot_load),
    .i_take  (w_slot_take),
    .i_flush (redirect_i),
    .i_instr (w_slot_instr_in),
    .i_pc    (w_slot_pc_in),
    .o_valid (w_slot_vld),
    .o_instr (instruction_o),
    .o_pc    (pc_o)
  );

  always_comb begin
    w_state_n = r_state;
    w_req     = 1'b0;
    case (r_state)
      FETCH_START: w_state_n = FETCH_RUN;
      FETCH_RUN: begin
        w_req = r_pend | w_room;
        if (redirect_i && w_req && !imem_ack_i) w_state_n = FETCH_DISCARD;
      end
      FETCH_DISCARD: begin
        w_req = 1'b1;
        // once the stale response lands, a same-cycle redirect just retargets r_pc
        if (imem_ack_i) w_state_n = FETCH_RUN;
      end
      default: w_state_n = FETCH_START;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= FETCH_START;
      r_pc    <= RESET_VECTOR & ALIGN_MASK;
      r_addr  <= RESET_VECTOR & ALIGN_MASK;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_req & ~imem_ack_i;
      // r_addr remembers the address of a request that DISCARD must keep driving
      if (r_state != FETCH_DISCARD) r_addr <= r_pc;
      if (redirect_i)  r_pc <= redirect_pc_i & ALIGN_MASK;
      else if (w_cap)  r_pc <= r_pc + XLEN'(PC_INC);
    end
  end

  assign imem_req_o   = w_req;
  assign imem_addr_o  = (r_state == FETCH_DISCARD) ? r_addr : r_pc;
  assign data_ready_o = w_slot_vld;
endmodule

// File: doc/rv32i_fetch.md
# rv32i_fetch

Instruction fetch stage at the head of the rv32i pipeline. Owns the program counter and issues word requests to instruction memory over a hold-until-ack bus. Presents each fetched instruction and its PC to the decode stage using the pipeline's data_ready / downstream_stall / downstream_execute handshake. Accepts redirects (branch, jump, trap) from later stages and discards any in-flight response that belongs to the old stream.

## Interface
- XLEN, 32, datapath and address width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset

- clk_i  in  1  clock; all state updates on the rising edge
- reset_ni  in  1  reset, asynchronous, active-low
- imem_req_o  out  1  instruction memory request
- imem_addr_o  out  XLEN  word-aligned fetch address; bits [1:0] always 0
- imem_ack_i  in  1  request accepted, data valid this cycle
- imem_data_i  in  XLEN  instruction word, sampled when imem_ack_i=1
- data_ready_o  out  1  instruction_o/pc_o hold a valid instruction for decode
- instruction_o  out  XLEN  fetched instruction
- pc_o  out  XLEN  address of instruction_o
- downstream_stall_i  in  1  decode cannot accept
- downstream_execute_i  in  1  decode consumes the presented instruction this cycle
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  XLEN  new fetch address; bits [1:0] forced to 0

## Operation
- Reset (asynchronous assert): data_ready_o=0, imem_req_o=0, instruction_o=0, pc_o=0, fetch PC=RESET_VECTOR, state=START.
- FSM states: START, FETCH, DISCARD.
  - START: req low for one cycle, then FETCH.
  - FETCH: imem_req_o=1 whenever the output slot is free (data_ready_o=0) or is consumed this cycle (downstream_execute_i=1). On ack, capture imem_data_i and the fetch PC into the output slot, set data_ready_o, fetch PC += 4 (wraps modulo 2^XLEN).
  - DISCARD: entered on redirect while a request is outstanding without ack. imem_req_o stays 1 with the old address until imem_ack_i; the response is dropped; then FETCH from the redirected PC.
- Bus rule: once imem_req_o rises, imem_addr_o and imem_req_o are held until imem_ack_i. Requests are never withdrawn.
- Consumption: downstream_execute_i with data_ready_o=1 frees the slot. If an ack lands the same cycle, the slot refills and data_ready_o stays 1; otherwise data_ready_o falls.
- downstream_stall_i is informational only: the slot holds while downstream_execute_i=0, and stall only blocks new requests through the slot-free rule.
- Redirect (highest priority, overrides consume and ack capture):
  - next cycle: data_ready_o=0, fetch PC=redirect_pc_i & ~3.
  - an ack in the redirect cycle is dropped and FETCH continues at the new PC.
  - an outstanding request without ack moves the FSM to DISCARD.
  - a redirect during DISCARD updates the target PC and stays in DISCARD.
  - a redirect in START is honoured; the first fetch goes to the redirected PC.

## Timing
- Zero-wait memory (ack in the request cycle): data_ready_o rises the cycle after the request, i.e. one cycle of latency.
- First request: second cycle after reset_ni deasserts.
- Without prefetch, sustained throughput is one instruction per cycle only while decode consumes every cycle. Full slot plus no consume means no request.
- Redirect-to-first-request: one cycle from FETCH. From DISCARD: one cycle after the discarded ack.

## Configuration
- RV32I_FETCH_PREFETCH_EN defined: adds a one-entry prefetch buffer behind the output slot. Requests issue while the slot is full and the buffer is empty. An ack with a full, unconsumed slot fills the buffer, and the buffer moves into the slot on consume. Redirect flushes the buffer.
- Undefined: no buffer; requests issue only under the slot-free rule above.
- Both builds must produce an identical instruction/PC sequence at decode.

## Structure
- Shared package rv32i_pkg: XLEN, RESET_VECTOR default, fetch FSM state enum (FETCH_START, FETCH_RUN, FETCH_DISCARD), and the PC increment constant 4.
- One sub-module: rv32i_fetch_buffer, the single-entry instruction+PC holding register with valid/load/take/flush. It is instantiated for the output slot and, under RV32I_FETCH_PREFETCH_EN, a second time for the prefetch entry.

## Test plan
- Reset release with zero-wait memory returning 32'h0000_0013 at every address: first req at addr 0 in cycle 2, data_ready_o=1 in cycle 3, pc_o = 0, 4, 8… on consecutive consumes.
- Decode withholds downstream_execute_i for 5 cycles: instruction_o/pc_o stable, no new request without prefetch; exactly one extra request with prefetch; no instruction lost or duplicated.
- Memory ack delayed 3 cycles: imem_addr_o constant and req high throughout; data captured only on the ack cycle.
- Redirect to 32'h0000_0102 while a request to 0x10 awaits ack: DISCARD, 0x10 data dropped, next request addr 32'h0000_0100, pc_o=0x100.
- Redirect in the same cycle as ack and consume: captured word dropped, data_ready_o=0 next cycle, next fetch at the redirect target.
- PC at 32'hFFFF_FFFC fetched and consumed: next request addr 32'h0000_0000; async reset asserted mid-wait clears data_ready_o and req immediately.
